pc_update_unit: RTL and testbench

PC_UPDATE_UNIT -- requirements
Module: pc_update_unit

---
 rtl/pc_update_unit.sv | 133 +++++++++++++
 tb/tb_pc_update_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_update_unit.sv
// PC update unit: next-PC selection, halt/misalign FSM, retirement counter.
// Optional taken-branch counter enabled by defining BRANCH_STATS_EN.
module pc_update_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        is_branch,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic        alu_bcond,
    input  logic [31:0] alu_result,
    input  logic [31:0] imm,
    input  logic        is_ecall,
    input  logic        halt_cond,
    output logic [31:0] current_pc,
    output logic [31:0] pc_plus_4,
    output logic        is_halted,
    output logic        misalign_fault,
`ifdef BRANCH_STATS_EN
    output logic [31:0] taken_count,
`endif
    output logic [31:0] retired_count
);

    typedef enum logic [1:0] {
        RUN          = 2'd0,
        HALT_PENDING = 2'd1,
        HALTED       = 2'd2
    } state_t;

    state_t      r_state, w_state_nx;
    logic [31:0] r_pc, w_pc_nx;
    logic [31:0] r_retired, w_retired_nx;
    logic        r_fault, w_fault_nx;

    logic        w_taken;
    logic        w_halt_req;
    logic        w_nonseq;
    logic        w_misalign;
    logic        w_retire;
    logic [31:0] w_seq;
    logic [31:0] w_rel;
    logic [31:0] w_jalr_tgt;
    logic [31:0] w_target;

    assign w_taken    = is_branch & alu_bcond;
    assign w_halt_req = is_ecall & halt_cond;
    assign w_nonseq   = is_jalr | is_jal | w_taken;
    assign w_seq      = r_pc + 32'd4;
    assign w_rel      = r_pc + imm;
    assign w_jalr_tgt = alu_result & ~32'd1;

    always_comb begin
        w_target = w_seq;
        if (is_jalr)
            w_target = w_jalr_tgt;
        else if (is_jal || w_taken)
            w_target = w_rel;
    end

    assign w_misalign = w_nonseq & w_target[1];

    // ECALL halt outranks any control transfer in the same cycle
    always_comb begin
        w_state_nx   = r_state;
        w_pc_nx      = r_pc;
        w_retired_nx = r_retired;
        w_fault_nx   = r_fault;
        w_retire     = 1'b0;
        unique case (r_state)
            RUN: begin
                if (!stall) begin
                    if (w_halt_req) begin
                        w_retired_nx = r_retired + 32'd1;
                        w_state_nx   = HALT_PENDING;
                    end else if (w_misalign) begin
                        w_fault_nx = 1'b1;
                        w_state_nx = HALTED;
                    end else begin
                        w_pc_nx      = w_target;
                        w_retired_nx = r_retired + 32'd1;
                        w_retire     = 1'b1;
                    end
                end
            end
            HALT_PENDING: w_state_nx = HALTED;
            HALTED:       w_state_nx = HALTED;
            default:      w_state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= RUN;
            r_pc      <= RESET_PC;
            r_retired <= 32'd0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_pc      <= w_pc_nx;
            r_retired <= w_retired_nx;
            r_fault   <= w_fault_nx;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] r_taken;
    logic        w_count_taken;

    assign w_count_taken = w_retire & w_taken & ~is_jal & ~is_jalr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_taken <= 32'd0;
        else if (w_count_taken)
            r_taken <= r_taken + 32'd1;
    end

    assign taken_count = r_taken;
`else
    logic w_unused;
    assign w_unused = w_retire;
`endif

    assign current_pc     = r_pc;
    assign pc_plus_4      = w_seq;
    assign is_halted      = (r_state == HALTED);
    assign misalign_fault = r_fault;
    assign retired_count  = r_retired;

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed bench for pc_update_unit: vector table plus halt/stall/reset sequences.
// Define BRANCH_STATS_EN for both files to exercise the taken-branch counter.
module tb_pc_update_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall, is_branch, is_jal, is_jalr, alu_bcond;
    logic        is_ecall, halt_cond;
    logic [31:0] alu_result, imm;
    logic [31:0] current_pc, pc_plus_4, retired_count;
    logic        is_halted, misalign_fault;
`ifdef BRANCH_STATS_EN
    logic [31:0] taken_count;
`endif

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pc_update_unit #(.RESET_PC(32'h0)) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall),
        .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
        .alu_bcond(alu_bcond), .alu_result(alu_result), .imm(imm),
        .is_ecall(is_ecall), .halt_cond(halt_cond),
        .current_pc(current_pc), .pc_plus_4(pc_plus_4),
        .is_halted(is_halted), .misalign_fault(misalign_fault),
`ifdef BRANCH_STATS_EN
        .taken_count(taken_count),
`endif
        .retired_count(retired_count)
    );

    typedef struct {
        string       name;
        logic        st, br, jl, jr, bc, ec, hc;
        logic [31:0] alu, im;
        logic [31:0] e_pc, e_cnt;
        logic        e_halt, e_fault;
    } vec_t;

    vec_t vt[15];

    function automatic vec_t mk(string n, logic st, logic br, logic jl,
                                logic jr, logic bc, logic ec, logic hc,
                                logic [31:0] alu, logic [31:0] im,
                                logic [31:0] pc, logic [31:0] cnt,
                                logic h, logic f);
        vec_t v;
        v.name = n; v.st = st; v.br = br; v.jl = jl; v.jr = jr;
        v.bc = bc; v.ec = ec; v.hc = hc; v.alu = alu; v.im = im;
        v.e_pc = pc; v.e_cnt = cnt; v.e_halt = h; v.e_fault = f;
        return v;
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", n, act, exp);
    endtask

    task automatic drive(logic st, logic br, logic jl, logic jr, logic bc,
                         logic ec, logic hc, logic [31:0] alu,
                         logic [31:0] im);
        stall = st; is_branch = br; is_jal = jl; is_jalr = jr;
        alu_bcond = bc; is_ecall = ec; halt_cond = hc;
        alu_result = alu; imm = im;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(string n, logic [31:0] pc, logic [31:0] cnt,
                               logic h, logic f);
        chk({n, ".pc"}, current_pc, pc);
        chk({n, ".cnt"}, retired_count, cnt);
        chk({n, ".halt"}, {31'd0, is_halted}, {31'd0, h});
        chk({n, ".fault"}, {31'd0, misalign_fault}, {31'd0, f});
    endtask

    task automatic do_reset;
        drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        reset_n = 1'b0;
        #12;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);

        //         name      st br jl jr bc ec hc alu          imm           pc           cnt h f
        vt[0]  = mk("seq1",  0, 0, 0, 0, 0, 0, 0, 32'h0,       32'h0,        32'h4,       1,  0,0);
        vt[1]  = mk("seq2",  0, 0, 0, 0, 0, 0, 0, 32'h0,       32'h0,        32'h8,       2,  0,0);
        vt[2]  = mk("seq3",  0, 0, 0, 0, 0, 0, 0, 32'h0,       32'h0,        32'hC,       3,  0,0);
        vt[3]  = mk("jal4",  0, 0, 1, 0, 0, 0, 0, 32'h0,       32'h4,        32'h10,      4,  0,0);
        vt[4]  = mk("btkn",  0, 1, 0, 0, 1, 0, 0, 32'h0,       32'hFFFFFFF8, 32'h8,       5,  0,0);
        vt[5]  = mk("jal8",  0, 0, 1, 0, 0, 0, 0, 32'h0,       32'h8,        32'h10,      6,  0,0);
        vt[6]  = mk("bnt",   0, 1, 0, 0, 0, 0, 0, 32'h0,       32'hFFFFFFF8, 32'h14,      7,  0,0);
        vt[7]  = mk("bcnob", 0, 0, 0, 0, 1, 0, 0, 32'h0,       32'h100,      32'h18,      8,  0,0);
        vt[8]  = mk("stall", 1, 0, 1, 0, 0, 0, 0, 32'h0,       32'h40,       32'h18,      8,  0,0);
        vt[9]  = mk("jalr",  0, 0, 1, 1, 0, 0, 0, 32'h101,     32'h40,       32'h100,     9,  0,0);
        vt[10] = mk("jwrap", 0, 0, 1, 0, 0, 0, 0, 32'h0,       32'hFFFFFEFC, 32'hFFFFFFFC,10, 0,0);
        vt[11] = mk("swrap", 0, 0, 0, 0, 0, 0, 0, 32'h0,       32'h0,        32'h0,       11, 0,0);
        vt[12] = mk("ecnh",  0, 0, 0, 0, 0, 1, 0, 32'h0,       32'h0,        32'h4,       12, 0,0);
        vt[13] = mk("misal", 0, 0, 1, 1, 0, 0, 0, 32'h102,     32'h8,        32'h4,       12, 1,1);
        vt[14] = mk("frozn", 0, 0, 1, 0, 0, 0, 0, 32'h0,       32'h8,        32'h4,       12, 1,1);

        do_reset();
        #1;
        check_state("reset", 32'h0, 32'h0, 0, 0);
        chk("pc4", pc_plus_4, 32'h4);

        for (int i = 0; i < 15; i++) begin
            drive(vt[i].st, vt[i].br, vt[i].jl, vt[i].jr, vt[i].bc,
                  vt[i].ec, vt[i].hc, vt[i].alu, vt[i].im);
            tick();
            check_state(vt[i].name, vt[i].e_pc, vt[i].e_cnt,
                        vt[i].e_halt, vt[i].e_fault);
        end

        // async reset out of a faulted HALTED state
        #2;
        reset_n = 1'b0;
        #1;
        check_state("arst_flt", 32'h0, 32'h0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // ECALL halt at 0x20 with a competing JAL
        do_reset();
        drive(0, 0, 1, 0, 0, 0, 0, 32'h0, 32'h20);
        tick();
        check_state("to20", 32'h20, 32'h1, 0, 0);
        drive(0, 1, 1, 0, 1, 1, 1, 32'h0, 32'h8);
        tick();
        check_state("hpend", 32'h20, 32'h2, 0, 0);
        drive(1, 0, 1, 0, 0, 0, 0, 32'h0, 32'h8);
        tick();
        check_state("halted", 32'h20, 32'h2, 1, 0);
        drive(0, 0, 1, 0, 0, 0, 0, 32'h0, 32'h8);
        tick();
        tick();
        check_state("hfrozen", 32'h20, 32'h2, 1, 0);

        // stall hold, then reset mid HALT_PENDING
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 1, 0, 0, 0, 0, 32'h0, 32'h40);
            tick();
        end
        check_state("stall4", 32'h0, 32'h0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        tick();
        check_state("poststl", 32'h4, 32'h1, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 1, 32'h0, 32'h0);
        tick();
        check_state("hpend2", 32'h4, 32'h2, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check_state("arst_hp", 32'h0, 32'h0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check_state("restart", 32'h4, 32'h1, 0, 0);

`ifdef BRANCH_STATS_EN
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 0, 1, 0, 0, 32'h0, 32'h4);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 0, 0, 0, 0, 0, 32'h0, 32'h4);
            tick();
        end
        drive(1, 1, 0, 0, 1, 0, 0, 32'h0, 32'h4);
        tick();
        drive(0, 0, 1, 0, 0, 0, 0, 32'h0, 32'h4);
        tick();
        chk("taken", taken_count, 32'd5);
        chk("tk_cnt", retired_count, 32'd8);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
